// File: rtl/plot_sink_if.sv
// Pixel-plot bus from the shape drawers plus the raster-order readback stream.
// The master side is the drawer/downstream pair, the slave side is plot_sink.
interface plot_sink_if;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot,
        input  out_x, out_y, out_colour, out_valid,
        output out_ready
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot,
        output out_x, out_y, out_colour, out_valid,
        input  out_ready
    );
endinterface

// File: rtl/plot_sink.sv
// Captures drawer plot strobes into a WIDTHxHEIGHT 3-bit framebuffer, keeps
// write statistics, and can clear the buffer or stream it out in raster order.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | accept plots, wait for clear or dump
// S_CLEAR    | write 0 to one address per cycle, last address -> S_DONE
// S_DUMP_RD  | present read address to the memory (1-cycle latency)
// S_DUMP_OUT | hold pixel with out_valid until out_ready
// S_DONE     | one-cycle done pulse, back to S_IDLE
module plot_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    plot_sink_if.slave  pif,
    input  logic        clear,
    input  logic        dump,
    output logic        busy,
    output logic        done,
    output logic [14:0] plot_count,
    output logic [7:0]  oob_count,
    output logic [7:0]  drop_count
);

    localparam int DEPTH = WIDTH * HEIGHT;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [7:0]    X_LIM     = 8'(WIDTH);
    localparam logic [6:0]    Y_LIM     = 7'(HEIGHT);
    localparam logic [7:0]    X_MAX     = 8'(WIDTH - 1);
    localparam logic [6:0]    Y_MAX     = 7'(HEIGHT - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ROW_STEP  = AW'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_DUMP_RD  = 3'd2,
        S_DUMP_OUT = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] addr;
    logic [7:0]    cur_x;
    logic [6:0]    cur_y;
    logic [2:0]    rd_data;

    logic [2:0]    mem [0:DEPTH-1];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [2:0]    mem_wdata;
    logic          rd_en;

    logic          in_range;
    logic          idle_plot;
    logic          last_pix;
    logic [AW-1:0] plot_addr;

    assign in_range  = (pif.vga_x < X_LIM) && (pif.vga_y < Y_LIM);
    // A clear in the same cycle discards the plot entirely.
    assign idle_plot = (state == S_IDLE) && pif.vga_plot && !clear;
    assign last_pix  = (cur_x == X_MAX) && (cur_y == Y_MAX);
    assign plot_addr = AW'(pif.vga_y) * ROW_STEP + AW'(pif.vga_x);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (clear) begin
                    state_nxt = S_CLEAR;
                end else if (dump) begin
                    state_nxt = S_DUMP_RD;
                end
            end
            S_CLEAR: begin
                if (addr == ADDR_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DUMP_RD: begin
                state_nxt = S_DUMP_OUT;
            end
            S_DUMP_OUT: begin
                if (pif.out_ready) begin
                    state_nxt = last_pix ? S_DONE : S_DUMP_RD;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy           = 1'b0;
        done           = 1'b0;
        rd_en          = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = plot_addr;
        mem_wdata      = pif.vga_colour;
        pif.out_valid  = 1'b0;
        pif.out_x      = 8'd0;
        pif.out_y      = 7'd0;
        pif.out_colour = 3'd0;
        case (state)
            S_IDLE: begin
                mem_we = idle_plot && in_range;
            end
            S_CLEAR: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_waddr = addr;
                mem_wdata = 3'd0;
            end
            S_DUMP_RD: begin
                busy  = 1'b1;
                rd_en = 1'b1;
            end
            S_DUMP_OUT: begin
                busy           = 1'b1;
                pif.out_valid  = 1'b1;
                pif.out_x      = cur_x;
                pif.out_y      = cur_y;
                pif.out_colour = rd_data;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Framebuffer: one write port, one registered read port, contents not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read data only refreshes in S_DUMP_RD so it stays put during a stall.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr  <= '0;
            cur_x <= 8'd0;
            cur_y <= 7'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear || dump) begin
                        addr  <= '0;
                        cur_x <= 8'd0;
                        cur_y <= 7'd0;
                    end
                end
                S_CLEAR: begin
                    addr <= addr + 1'b1;
                end
                S_DUMP_OUT: begin
                    if (pif.out_ready && !last_pix) begin
                        addr <= addr + 1'b1;
                        if (cur_x == X_MAX) begin
                            cur_x <= 8'd0;
                            cur_y <= cur_y + 1'b1;
                        end else begin
                            cur_x <= cur_x + 1'b1;
                        end
                    end
                end
                default: begin
                    addr <= addr;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plot_count <= 15'd0;
            oob_count  <= 8'd0;
            drop_count <= 8'd0;
        end else if ((state == S_IDLE) && clear) begin
            plot_count <= 15'd0;
            oob_count  <= 8'd0;
            drop_count <= 8'd0;
        end else begin
            if (idle_plot && in_range && (plot_count != 15'h7fff)) begin
                plot_count <= plot_count + 1'b1;
            end
            if (idle_plot && !in_range && (oob_count != 8'hff)) begin
                oob_count <= oob_count + 1'b1;
            end
            if ((state != S_IDLE) && pif.vga_plot && (drop_count != 8'hff)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/plot_sink.md
# plot_sink

Receiving end of the pixel-plot interface driven by the shape drawers (circle, Reuleaux triangle). It captures every `vga_plot` strobe into an internal 160×120, 3-bit framebuffer and keeps write statistics. On request it clears the buffer, or streams the whole frame back out in raster order over a valid/ready handshake. Benches use it to check drawer output pixel by pixel; on hardware it can also serve as a shadow copy of the screen.

## Interface
- `WIDTH`, 160, framebuffer columns.
- `HEIGHT`, 120, framebuffer rows.
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `vga_x`  in  8  plot column.
- `vga_y`  in  7  plot row.
- `vga_colour`  in  3  plot colour.
- `vga_plot`  in  1  write strobe, one pixel per cycle while high.
- `clear`  in  1  start a clear; sampled only in IDLE.
- `dump`  in  1  start a readback; sampled only in IDLE.
- `out_x`  out  8  readback column.
- `out_y`  out  7  readback row.
- `out_colour`  out  3  readback colour.
- `out_valid`  out  1  readback pixel valid.
- `out_ready`  in  1  downstream accepts the readback pixel.
- `busy`  out  1  high in CLEAR, DUMP_RD and DUMP_OUT.
- `done`  out  1  one-cycle pulse when a clear or dump completes.
- `plot_count`  out  15  accepted in-range plots, saturating at 32767.
- `oob_count`  out  8  out-of-range plots, saturating at 255.
- `drop_count`  out  8  plots ignored while busy, saturating at 255.

## Operation
- Storage is WIDTH×HEIGHT words of 3 bits, with address = y*WIDTH + x (0..19199).
- The memory has one write port and one synchronous read port with 1-cycle read latency.
- Memory contents are not reset.
- States:
  - IDLE
  - CLEAR
  - DUMP_RD
  - DUMP_OUT
  - DONE
- IDLE:
  - `vga_plot`=1 with x<WIDTH and y<HEIGHT writes the colour and increments `plot_count`.
  - Otherwise, `vga_plot`=1 increments `oob_count` and writes nothing.
  - `clear`=1 resets all three counters to 0 and moves to CLEAR with the address counter at 0.
  - `clear` wins over `dump` when both are high in the same cycle.
  - If `vga_plot` is also high in that cycle, the plot is discarded and not counted.
  - Otherwise `dump`=1 moves to DUMP_RD with the address counter at 0.
- CLEAR:
  - Writes 0 to the current address each cycle, then increments it.
  - After writing address 19199, moves to DONE.
- DUMP_RD: presents the read address, then moves to DUMP_OUT.
- DUMP_OUT:
  - Holds `out_valid`=1 with `out_x`/`out_y` of the current address and `out_colour` from memory.
  - All three outputs stay stable until `out_ready`=1.
  - On that handshake: if the pixel was the last one (x=WIDTH-1, y=HEIGHT-1), move to DONE.
  - Otherwise advance x, wrapping to 0 with y+1, and return to DUMP_RD.
- DONE: `done`=1 for this cycle only, then return to IDLE.
- `vga_plot`=1 in any state other than IDLE increments `drop_count`; no write occurs.
- `clear` and `dump` outside IDLE are ignored.
- Counters saturate at their maximum and never wrap.

## Timing
- Reset values:
  - state IDLE
  - all outputs 0
  - all counters 0
- Reset is honoured mid-operation: a CLEAR or dump in progress aborts immediately.
- After an aborted CLEAR, the memory is partially cleared.
- A plot accepted at edge N is visible to a dump sampled at edge N+1 or later.
- Clear:
  - `clear` is sampled at edge E.
  - Edges E+1..E+19200 write addresses 0..19199, with `busy`=1 from E through E+19200.
  - `done`=1 and `busy`=0 in the cycle after E+19200.
  - The first new plot can be accepted at E+19202.
- Dump:
  - Each pixel costs 2 cycles with `out_ready` held high, so a full frame takes 38400 cycles plus the DONE cycle.
  - `out_valid` is first high in the cycle after the first DUMP_RD cycle.
  - `out_valid` never drops without a handshake.
- `plot_count`, `oob_count` and `drop_count` update on the edge that samples the plot.

## Test plan
- Reset, then clear, then dump with `out_ready`=1:
  - `done` one cycle after 19200 busy cycles.
  - The dump yields 19200 pixels, all colour 0, ordered (0,0),(1,0)…(159,119).
  - `done` pulses after the last pixel.
- Plot (5,7,c=3), (159,119,c=6), (160,0,c=1) and (0,120,c=2), then dump:
  - Only the two in-range pixels are non-zero.
  - `plot_count`=2 and `oob_count`=2.
- Plot (10,10,c=5) twice, then (10,10,c=2), then dump: pixel (10,10) reads 2, and `plot_count`=3.
- Dump with `out_ready` toggling 1,0,0,1:
  - `out_x`/`out_y`/`out_colour` stay stable while stalled.
  - No pixel is skipped or duplicated.
- Assert `vga_plot` for 300 cycles during a dump: `drop_count` saturates at 255 and the framebuffer is unchanged.
- Assert `clear` and `dump` together in IDLE:
  - CLEAR is taken.
  - Deassert `rst_n` at clear address 5000: all outputs go to 0, state returns to IDLE, and a new `dump` is accepted.
